maxpool_stream: RTL and testbench

- 2x2, stride-2 signed int8 max-pooling stage with AXI-Stream in/out and an APB slave for configuration and status.
- Sits directly downstream of the conv engine inside compute_top. It consumes conv output feature maps on the vdma2 mm2s stream and returns pooled maps on vdma2 s2mm.
- Streams one frame of WIDTH x HEIGHT pixels and emits (WIDTH/2) x (HEIGHT/2) pixels, using a single-row line buffer.

---
 rtl/maxpool_stream.sv | 190 +++++++++++++++++++
 tb/tb_maxpool_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// 2x2 stride-2 signed int8 max-pool over a 4-pixel AXI-Stream with APB config/status.
// Optional MAXPOOL_RELU_EN clamps negative pooled bytes to zero before the output register.
module maxpool_stream #(
    parameter int MAX_WIDTH = 256,
    parameter int APB_AW    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              S_AXIS_TREADY,
    input  logic [31:0]       S_AXIS_TDATA,
    input  logic [3:0]        S_AXIS_TKEEP,
    input  logic              S_AXIS_TUSER,
    input  logic              S_AXIS_TLAST,
    input  logic              S_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [31:0]       M_AXIS_TDATA,
    output logic [3:0]        M_AXIS_TKEEP,
    output logic              M_AXIS_TUSER,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);
    localparam int LB_DEPTH = MAX_WIDTH / 4;
    localparam int CW       = $clog2(LB_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [15:0]   width_q, height_q, row_q;
    logic [31:0]   outcnt_q, prdata_q, mdata_q;
    logic [CW-1:0] col_q;
    logic          done_q, err_q, last_in_q;
    logic          mvalid_q, muser_q, mlast_q;
    logic [15:0]   stage_q;
    logic [15:0]   lbuf [LB_DEPTH];

    function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [7:0] act(input logic [7:0] x);
`ifdef MAXPOOL_RELU_EN
        return x[7] ? 8'h00 : x;
`else
        return x;
`endif
    endfunction

    // APB decode
    logic       apb_err, apb_wr, start_req, busy, cfg_bad;
    logic [1:0] reg_sel;
    logic [31:0] rd_mux;

    assign reg_sel   = PADDR[3:2];
    assign apb_err   = PADDR[APB_AW-1:4] != '0;
    assign apb_wr    = PSEL & PENABLE & PWRITE & !apb_err;
    assign start_req = apb_wr & (reg_sel == 2'd0) & PWDATA[0];
    assign busy      = state_q != S_IDLE;
    assign cfg_bad   = (width_q == 16'd0) | (width_q[2:0] != 3'd0) | (width_q > 16'(MAX_WIDTH)) |
                       (height_q == 16'd0) | height_q[0];

    always_comb begin
        rd_mux = 32'd0;
        if (!apb_err) begin
            case (reg_sel)
                2'd0: rd_mux = {29'd0, err_q, done_q, busy};
                2'd1: rd_mux = {16'd0, width_q};
                2'd2: rd_mux = {16'd0, height_q};
                default: rd_mux = outcnt_q;
            endcase
        end
    end

    // Datapath
    logic [7:0]  h0, h1, v0, v1;
    logic [15:0] lb_rd;
    logic        in_acc, out_acc, load, col_last, row_last;

    assign lb_rd    = lbuf[col_q];
    assign h0       = smax(S_AXIS_TDATA[7:0],   S_AXIS_TDATA[15:8]);
    assign h1       = smax(S_AXIS_TDATA[23:16], S_AXIS_TDATA[31:24]);
    assign v0       = act(smax(h0, lb_rd[7:0]));
    assign v1       = act(smax(h1, lb_rd[15:8]));
    assign col_last = col_q == CW'(width_q[15:2] - 14'd1);
    assign row_last = row_q == (height_q - 16'd1);

    assign S_AXIS_TREADY = (state_q == S_RUN) & (!mvalid_q | M_AXIS_TREADY) & !last_in_q;
    assign in_acc  = S_AXIS_TVALID & S_AXIS_TREADY;
    assign out_acc = mvalid_q & M_AXIS_TREADY;
    assign load    = in_acc & row_q[0] & col_q[0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            width_q   <= 16'd0;
            height_q  <= 16'd0;
            row_q     <= 16'd0;
            col_q     <= '0;
            outcnt_q  <= 32'd0;
            prdata_q  <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            last_in_q <= 1'b0;
            mvalid_q  <= 1'b0;
            mdata_q   <= 32'd0;
            muser_q   <= 1'b0;
            mlast_q   <= 1'b0;
            stage_q   <= 16'd0;
        end else begin
            // Read data is captured in the setup phase so it is stable during access.
            if (PSEL && !PENABLE && !PWRITE)
                prdata_q <= rd_mux;
            if (apb_wr && state_q == S_IDLE) begin
                if (reg_sel == 2'd1) width_q  <= PWDATA[15:0];
                if (reg_sel == 2'd2) height_q <= PWDATA[15:0];
            end

            case (state_q)
                S_IDLE: if (start_req) begin
                    done_q   <= 1'b0;
                    outcnt_q <= 32'd0;
                    if (cfg_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q     <= 1'b0;
                        state_q   <= S_RUN;
                        col_q     <= '0;
                        row_q     <= 16'd0;
                        last_in_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (in_acc) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_last ? 16'd0 : row_q + 16'd1;
                            if (row_last) last_in_q <= 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    if (out_acc) begin
                        outcnt_q <= outcnt_q + 32'd1;
                        if (mlast_q) state_q <= S_DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase

            if (in_acc && row_q[0] && !col_q[0])
                stage_q <= {v1, v0};
            if (load) begin
                mvalid_q <= 1'b1;
                mdata_q  <= {v1, v0, stage_q};
                muser_q  <= (row_q == 16'd1) && (col_q == CW'(1));
                mlast_q  <= col_last && row_last;
            end else if (out_acc) begin
                mvalid_q <= 1'b0;
            end
        end
    end

    // Line buffer holds horizontal maxima of the even row; contents need no reset.
    always_ff @(posedge CLK) begin
        if (in_acc && !row_q[0])
            lbuf[col_q] <= {h1, h0};
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXIS_TKEEP, S_AXIS_TUSER, S_AXIS_TLAST, PADDR[1:0]};

    assign M_AXIS_TDATA  = mdata_q;
    assign M_AXIS_TKEEP  = 4'hF;
    assign M_AXIS_TUSER  = muser_q;
    assign M_AXIS_TLAST  = mlast_q;
    assign M_AXIS_TVALID = mvalid_q;
    assign PRDATA        = prdata_q;
    assign PREADY        = 1'b1;
    assign PSLVERR       = PSEL & PENABLE & apb_err;
endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: vector table of frames plus reset, bad-config and APB sequences.
module tb_maxpool_stream;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TKEEP;
    logic        S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TVALID;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    maxpool_stream dut (
        .CLK(CLK), .RESET(RESET),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
        .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int               w;
        int               h;
        logic [15:0][31:0] beats;
        int               nb;
        logic [3:0][31:0] exp;
        int               ne;
        bit               bp;
    } vec_t;
    vec_t vecs[4];

    // Output monitor: drives M_AXIS_TREADY, collects accepted words, watches stall rules.
    logic [31:0] got_d[$];
    logic        got_u[$];
    logic        got_l[$];
    bit          bp_en = 1'b0;
    int          stall_bad = 0;
    logic [31:0] prev_d;
    bit          prev_stall = 1'b0;

    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(negedge CLK);
            M_AXIS_TREADY = bp_en ? (($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0) : 1'b1;
            #2;
            if (prev_stall && M_AXIS_TDATA !== prev_d) stall_bad++;
            if (M_AXIS_TVALID && !M_AXIS_TREADY && S_AXIS_TREADY) stall_bad++;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                got_d.push_back(M_AXIS_TDATA);
                got_u.push_back(M_AXIS_TUSER);
                got_l.push_back(M_AXIS_TLAST);
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_d     = M_AXIS_TDATA;
        end
    end

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(negedge CLK); PENABLE = 1;
        @(negedge CLK); PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge CLK); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(negedge CLK); PENABLE = 1;
        #1 d = PRDATA; e = PSLVERR;
        chk("pready", 32'(PREADY), 32'd1);
        @(negedge CLK); PSEL = 0; PENABLE = 0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        bit acc = 1'b0;
        int t = 0;
        @(negedge CLK); S_AXIS_TVALID = 1; S_AXIS_TDATA = d;
        while (!acc && t < 200) begin
            #1 acc = S_AXIS_TREADY;
            @(posedge CLK);
            if (!acc) begin
                @(negedge CLK);
                t++;
            end
        end
        chk("beat_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got_d.size() < n && t < 500) begin
            @(negedge CLK);
            t++;
        end
    endtask

    task automatic clear_got();
        got_d.delete(); got_u.delete(); got_l.delete();
    endtask

    task automatic run_vec(input int i);
        logic [31:0] rd;
        logic        er;
        clear_got();
        apb_wr(32'h4, 32'(vecs[i].w));
        apb_wr(32'h8, 32'(vecs[i].h));
        bp_en = vecs[i].bp;
        apb_wr(32'h0, 32'h1);
        for (int b = 0; b < vecs[i].nb; b++) send_beat(vecs[i].beats[b]);
        @(negedge CLK); S_AXIS_TVALID = 0;
        wait_out(vecs[i].ne);
        bp_en = 1'b0;
        chk($sformatf("v%0d_count", i), 32'(got_d.size()), 32'(vecs[i].ne));
        for (int k = 0; k < got_d.size() && k < vecs[i].ne; k++) begin
            chk($sformatf("v%0d_data%0d", i, k), got_d[k], vecs[i].exp[k]);
            chk($sformatf("v%0d_user%0d", i, k), 32'(got_u[k]), 32'(k == 0));
            chk($sformatf("v%0d_last%0d", i, k), 32'(got_l[k]), 32'(k == vecs[i].ne - 1));
        end
        repeat (3) @(negedge CLK);
        apb_rd(32'h0, rd, er);
        chk($sformatf("v%0d_ctrl", i), rd, 32'h2);
        apb_rd(32'hC, rd, er);
        chk($sformatf("v%0d_outcnt", i), rd, 32'(vecs[i].ne));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [7:0]  x;

        vecs[0].w = 8; vecs[0].h = 2; vecs[0].nb = 4; vecs[0].ne = 1; vecs[0].bp = 0;
        vecs[0].beats[0] = 32'h04030201; vecs[0].beats[1] = 32'h08070605;
        vecs[0].beats[2] = 32'h0C0B0A09; vecs[0].beats[3] = 32'h100F0E0D;
        vecs[0].exp[0] = 32'h100E0C0A;

        vecs[1].w = 8; vecs[1].h = 2; vecs[1].nb = 4; vecs[1].ne = 1; vecs[1].bp = 0;
        vecs[1].beats[0] = 32'h80808080; vecs[1].beats[1] = 32'h80808080;
        vecs[1].beats[2] = 32'hFFFFFFFF; vecs[1].beats[3] = 32'hFFFFFFFF;

        vecs[2].w = 8; vecs[2].h = 2; vecs[2].nb = 4; vecs[2].ne = 1; vecs[2].bp = 0;
        vecs[2].beats[0] = 32'h01FE7F80; vecs[2].beats[1] = 32'h80808080;
        vecs[2].beats[2] = 32'h02FF0081; vecs[2].beats[3] = 32'hF0E0C0D0;
`ifdef MAXPOOL_RELU_EN
        vecs[1].exp[0] = 32'h00000000;
        vecs[2].exp[0] = 32'h0000027F;
`else
        vecs[1].exp[0] = 32'hFFFFFFFF;
        vecs[2].exp[0] = 32'hF0D0027F;
`endif

        // 16x4 frame: row bases 0x00/0x40/0x60/0x50 (+4 per beat), bytes base..base+3
        vecs[3].w = 16; vecs[3].h = 4; vecs[3].nb = 16; vecs[3].ne = 4; vecs[3].bp = 1;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                x = 8'((r == 0) ? 0 : (r == 1) ? 'h40 : (r == 2) ? 'h60 : 'h50) + 8'(4 * k);
                vecs[3].beats[r * 4 + k] = {x + 8'd3, x + 8'd2, x + 8'd1, x};
            end
        vecs[3].exp[0] = 32'h47454341; vecs[3].exp[1] = 32'h4F4D4B49;
        vecs[3].exp[2] = 32'h67656361; vecs[3].exp[3] = 32'h6F6D6B69;

        RESET = 1; S_AXIS_TDATA = 0; S_AXIS_TKEEP = 4'hF; S_AXIS_TUSER = 0; S_AXIS_TLAST = 0;
        S_AXIS_TVALID = 0; PADDR = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0;
        repeat (3) @(negedge CLK);
        RESET = 0;
        chk("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
        chk("rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rst_m_tdata", M_AXIS_TDATA, 32'd0);
        chk("rst_m_tuser", 32'(M_AXIS_TUSER), 32'd0);
        chk("rst_m_tlast", 32'(M_AXIS_TLAST), 32'd0);
        chk("rst_m_tkeep", 32'(M_AXIS_TKEEP), 32'hF);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        apb_rd(32'h0, rd, er); chk("rst_ctrl", rd, 32'd0);
        apb_rd(32'h4, rd, er); chk("rst_width", rd, 32'd0);
        apb_rd(32'hC, rd, er); chk("rst_outcnt", rd, 32'd0);

        for (int i = 0; i < 4; i++) run_vec(i);
        chk("stall_rules", 32'(stall_bad), 32'd0);

        // Bad configurations must flag ERR and never open the input
        apb_wr(32'h4, 32'd12); apb_wr(32'h8, 32'd2); apb_wr(32'h0, 32'h1);
        @(negedge CLK); S_AXIS_TVALID = 1; #1;
        chk("bad_w12_tready", 32'(S_AXIS_TREADY), 32'd0);
        apb_rd(32'h0, rd, er); chk("bad_w12_ctrl", rd, 32'h4);
        apb_wr(32'h4, 32'd8); apb_wr(32'h8, 32'd3); apb_wr(32'h0, 32'h1);
        #1 chk("bad_h3_tready", 32'(S_AXIS_TREADY), 32'd0);
        apb_rd(32'h0, rd, er); chk("bad_h3_ctrl", rd, 32'h4);
        apb_wr(32'h4, 32'd264); apb_wr(32'h8, 32'd2); apb_wr(32'h0, 32'h1);
        #1 chk("bad_w264_tready", 32'(S_AXIS_TREADY), 32'd0);
        apb_rd(32'h0, rd, er); chk("bad_w264_ctrl", rd, 32'h4);
        @(negedge CLK); S_AXIS_TVALID = 0;
        run_vec(0);

        // APB error decode and config lock while busy
        apb_rd(32'h10, rd, er); chk("apb_unmapped_slverr", 32'(er), 32'd1);
        apb_rd(32'h4, rd, er);  chk("apb_mapped_slverr", 32'(er), 32'd0);
        clear_got();
        apb_wr(32'h0, 32'h1);
        send_beat(vecs[0].beats[0]);
        @(negedge CLK); S_AXIS_TVALID = 0;
        apb_wr(32'h4, 32'd32);
        apb_rd(32'h4, rd, er); chk("busy_width_locked", rd, 32'd8);
        apb_rd(32'h0, rd, er); chk("busy_ctrl", rd, 32'h1);
        for (int b = 1; b < 4; b++) send_beat(vecs[0].beats[b]);
        @(negedge CLK); S_AXIS_TVALID = 0;
        wait_out(1);
        chk("busy_frame_count", 32'(got_d.size()), 32'd1);
        if (got_d.size() > 0) chk("busy_frame_data", got_d[0], 32'h100E0C0A);
        repeat (3) @(negedge CLK);

        // Reset in the middle of a frame
        apb_wr(32'h0, 32'h1);
        for (int b = 0; b < 3; b++) send_beat(vecs[0].beats[b]);
        @(negedge CLK); RESET = 1; S_AXIS_TVALID = 0;
        @(negedge CLK); RESET = 0;
        chk("mid_rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
        chk("mid_rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("mid_rst_m_tdata", M_AXIS_TDATA, 32'd0);
        chk("mid_rst_prdata", PRDATA, 32'd0);
        chk("mid_rst_pslverr", 32'(PSLVERR), 32'd0);
        apb_rd(32'h0, rd, er); chk("mid_rst_ctrl", rd, 32'd0);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
